mips_boot_ctrl: RTL and testbench
=================================

# mips_boot_ctrl

Single-clock boot and self-check controller for the pipelined MIPS32 core. It streams a program image into instruction/data memory and writes one operand word. It then releases the core, waits for HALTED, and reads back and compares one result word. Replaces hand-written per-program bench initial blocks with a reusable, parametrised sequencer that sits between a host/stimulus source and the core's memory port.

## Interface
Parameters:
- ADDR_W, 10, memory address width (words)
- DATA_W, 32, memory word width
- PROG_DEPTH, 16, max program words accepted per load (≤ 2^ADDR_W)
- TIMEOUT, 1000, run-phase cycle limit (used only with BOOTCTL_TIMEOUT_EN)

Ports:
- clk1  in  1  single system clock, all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- start  in  1  begin a boot/check sequence; sampled only in IDLE
- oper_addr  in  ADDR_W  operand write address; sampled at start
- oper_val  in  DATA_W  operand value; sampled at start
- chk_addr  in  ADDR_W  result read address; sampled at start
- exp_val  in  DATA_W  expected result; sampled at start
- ld_valid  in  1  program word valid
- ld_ready  out  1  controller accepts program word
- ld_data  in  DATA_W  program word
- ld_last  in  1  marks final program word
- mem_we  out  1  memory write strobe
- mem_re  out  1  memory read strobe
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  read data, valid one cycle after mem_re
- cpu_run  out  1  core enable (core PC/HALTED/TAKEN_BRANCH cleared by integrator while low)
- halted  in  1  core HALTED flag
- done  out  1  sequence complete
- pass  out  1  result matched exp_val
- fail  out  1  mismatch or timeout
- timeout  out  1  run aborted by watchdog
- cycles  out  32  core run cycles of last sequence, saturating

## Operation
- States: IDLE, LOAD, OPER, RUN, READ, CHECK, DONE.
- IDLE: ld_ready=0, all strobes 0. start=1 → latch oper_addr/oper_val/chk_addr/exp_val, clear load counter, cycles, pass/fail/timeout/done → LOAD.
- LOAD: ld_ready=1. Each handshake (ld_valid & ld_ready) writes ld_data at address = load counter (0,1,2…), counter increments. Handshake with ld_last=1, or the PROG_DEPTH-th handshake (implicit last) → OPER.
- OPER: one write of oper_val to oper_addr → RUN.
- RUN: cpu_run=1; cycles increments each RUN cycle, saturating at 32'hFFFF_FFFF. halted ignored in the first RUN cycle (stale flag); from the second, halted=1 → cpu_run drops, → READ.
- READ: mem_re=1, mem_addr=chk_addr → CHECK.
- CHECK: compare mem_rdata to exp_val; pass=(equal), fail=!(equal) → DONE.
- DONE: done=1; pass/fail/timeout/cycles held. start=1 → restart as from IDLE (same-cycle latch).
- start in any state other than IDLE/DONE is ignored.
- Write path priority: only one memory access per cycle; mem_we and mem_re never both high.

## Timing
- Reset: state IDLE; ld_ready, mem_we, mem_re, cpu_run, done, pass, fail, timeout = 0; mem_addr, mem_wdata, cycles = 0.
- All memory outputs registered: handshake at edge k → mem_we/mem_addr/mem_wdata valid in cycle k+1 (one cycle).
- OPER write occupies exactly one cycle after the final load write cycle.
- Minimum sequence for N words, H run cycles: 1 (start) + N + 1 (OPER) + H + 1 (READ) + 1 (CHECK) → done.
- ld_valid low stalls LOAD indefinitely; ld_ready held high.
- rst_n low in any state → reset values next edge, cpu_run drops immediately at that edge, partial program not completed.
- halted and timeout expiry in same cycle: halted wins, normal READ/CHECK.

## Configuration
- BOOTCTL_TIMEOUT_EN defined: run-phase watchdog; when cycles reaches TIMEOUT without halted, cpu_run drops, timeout=1, fail=1, pass=0, → DONE (READ/CHECK skipped).
- Not defined: RUN waits indefinitely for halted; timeout output tied 0; TIMEOUT parameter unused.

## Test plan
- Factorial: load 11-word loop program (ADDI/LW/MUL/SUBI/BNEQZ/SW/HLT), oper_addr=200, oper_val=7, chk_addr=198, exp_val=5040 → done=1, pass=1, fail=0, cycles>0.
- Mismatch: same program, exp_val=5041 → done=1, fail=1, pass=0.
- Depth cap: PROG_DEPTH=4, stream 6 words with ld_last never set → exactly 4 writes to addresses 0–3, ld_ready=0 afterward, then OPER write.
- Backpressure: ld_valid toggling every other cycle → writes only on handshake cycles, addresses contiguous, no duplicates.
- Timeout (BOOTCTL_TIMEOUT_EN, TIMEOUT=50): halted held 0 → cpu_run low after 50 RUN cycles, timeout=1, fail=1, no mem_re pulse.
- Reset mid-RUN: assert rst_n=0 for 1 cycle → next edge cpu_run=0, done=0, state IDLE; new start completes normally.

Source files
------------

// File: rtl/mips_boot_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mips_boot_ctrl
// Brief    : Boot and self-check sequencer for the pipelined MIPS32 core.
//            Streams a program image and one operand word into memory,
//            releases the core until HALTED, then reads back one result word
//            and compares it against an expected value.
// Options  : BOOTCTL_TIMEOUT_EN - enables the run-phase watchdog (TIMEOUT)
// Revision : 1.0 - initial release
// ============================================================================
module mips_boot_ctrl #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int PROG_DEPTH = 16,
  parameter int TIMEOUT    = 1000
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] oper_addr,
  input  logic [DATA_W-1:0] oper_val,
  input  logic [ADDR_W-1:0] chk_addr,
  input  logic [DATA_W-1:0] exp_val,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cpu_run,
  input  logic              halted,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic              timeout,
  output logic [31:0]       cycles
);

  localparam logic [2:0] c_st_idle  = 3'd0;
  localparam logic [2:0] c_st_load  = 3'd1;
  localparam logic [2:0] c_st_oper  = 3'd2;
  localparam logic [2:0] c_st_run   = 3'd3;
  localparam logic [2:0] c_st_read  = 3'd4;
  localparam logic [2:0] c_st_check = 3'd5;
  localparam logic [2:0] c_st_done  = 3'd6;

  // Index of the implicit final word when ld_last never arrives
  localparam logic [ADDR_W:0] c_last_idx = (ADDR_W+1)'(PROG_DEPTH - 1);
  // Watchdog fires on the RUN cycle that brings the count up to TIMEOUT
  localparam logic [31:0]     c_tmo_lim  = 32'(TIMEOUT - 1);

`ifdef BOOTCTL_TIMEOUT_EN
  localparam logic c_tmo_en = 1'b1;
`else
  localparam logic c_tmo_en = 1'b0;
`endif

  logic [2:0]        r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_oper_addr, r_chk_addr;
  logic [DATA_W-1:0] r_oper_val, r_exp_val;
  logic [ADDR_W:0]   r_ld_cnt;
  logic [31:0]       r_cycles;
  logic              r_pass, r_fail, r_timeout;
  logic              r_mem_we, r_mem_re;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              w_mem_we_nxt, w_mem_re_nxt;
  logic [ADDR_W-1:0] w_mem_addr_nxt;
  logic [DATA_W-1:0] w_mem_wdata_nxt;

  logic w_start_ok, w_hs, w_ld_end, w_tmo_hit, w_run_halt, w_run_tmo;

  assign w_start_ok = start && ((r_state == c_st_idle) || (r_state == c_st_done));
  assign w_hs       = ld_valid && (r_state == c_st_load);
  assign w_ld_end   = w_hs && (ld_last || (r_ld_cnt == c_last_idx));
  assign w_tmo_hit  = c_tmo_en && (r_cycles >= c_tmo_lim);
  // A zero cycle count marks the first RUN cycle, where HALTED is still stale
  assign w_run_halt = (r_state == c_st_run) && (r_cycles != 32'd0) && halted;
  assign w_run_tmo  = (r_state == c_st_run) && !w_run_halt && w_tmo_hit;

  // State register
  always_ff @(posedge clk1) begin
    if (!rst_n) r_state <= c_st_idle;
    else        r_state <= w_state_nxt;
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle:  if (start) w_state_nxt = c_st_load;
      c_st_load:  if (w_ld_end) w_state_nxt = c_st_oper;
      c_st_oper:  w_state_nxt = c_st_run;
      c_st_run: begin
        if (w_run_halt)     w_state_nxt = c_st_read;
        else if (w_run_tmo) w_state_nxt = c_st_done;
      end
      c_st_read:  w_state_nxt = c_st_check;
      c_st_check: w_state_nxt = c_st_done;
      c_st_done:  if (start) w_state_nxt = c_st_load;
      default:    w_state_nxt = c_st_idle;
    endcase
  end

  // Output decode: state-level handshakes plus next values of the memory port
  always_comb begin
    ld_ready        = (r_state == c_st_load);
    cpu_run         = (r_state == c_st_run);
    done            = (r_state == c_st_done);
    w_mem_we_nxt    = 1'b0;
    w_mem_re_nxt    = 1'b0;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    if (w_hs) begin
      w_mem_we_nxt    = 1'b1;
      w_mem_addr_nxt  = r_ld_cnt[ADDR_W-1:0];
      w_mem_wdata_nxt = ld_data;
    end else if (r_state == c_st_oper) begin
      w_mem_we_nxt    = 1'b1;
      w_mem_addr_nxt  = r_oper_addr;
      w_mem_wdata_nxt = r_oper_val;
    end else if (w_run_halt) begin
      w_mem_re_nxt    = 1'b1;
      w_mem_addr_nxt  = r_chk_addr;
    end
  end

  // Datapath: latched job, load counter, run counter, verdict and memory port
  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      r_oper_addr <= '0;
      r_oper_val  <= '0;
      r_chk_addr  <= '0;
      r_exp_val   <= '0;
      r_ld_cnt    <= '0;
      r_cycles    <= '0;
      r_pass      <= 1'b0;
      r_fail      <= 1'b0;
      r_timeout   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_re    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_mem_we    <= w_mem_we_nxt;
      r_mem_re    <= w_mem_re_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      if (w_start_ok) begin
        r_oper_addr <= oper_addr;
        r_oper_val  <= oper_val;
        r_chk_addr  <= chk_addr;
        r_exp_val   <= exp_val;
        r_ld_cnt    <= '0;
        r_cycles    <= '0;
        r_pass      <= 1'b0;
        r_fail      <= 1'b0;
        r_timeout   <= 1'b0;
      end
      if (w_hs) r_ld_cnt <= r_ld_cnt + (ADDR_W+1)'(1);
      if ((r_state == c_st_run) && (r_cycles != 32'hFFFF_FFFF))
        r_cycles <= r_cycles + 32'd1;
      if (r_state == c_st_check) begin
        r_pass <= (mem_rdata == r_exp_val);
        r_fail <= (mem_rdata != r_exp_val);
      end
      if (w_run_tmo) begin
        r_timeout <= 1'b1;
        r_fail    <= 1'b1;
        r_pass    <= 1'b0;
      end
    end
  end

  assign mem_we    = r_mem_we;
  assign mem_re    = r_mem_re;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign pass      = r_pass;
  assign fail      = r_fail;
  assign timeout   = r_timeout;
  assign cycles    = r_cycles;

endmodule
`default_nettype wire

// File: tb/tb_mips_boot_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_boot_ctrl
// Brief    : Self-checking bench for mips_boot_ctrl with a memory model and a
//            stand-in core that halts after a chosen number of run cycles and
//            stores a function of the operand word at the result address.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_boot_ctrl;
  localparam int AW    = 10;
  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int TMO   = 50;
`ifdef BOOTCTL_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic          clk1 = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] oper_addr = '0, chk_addr = '0;
  logic [DW-1:0] oper_val = '0, exp_val = '0;
  logic          ld_valid = 1'b0, ld_last = 1'b0;
  logic [DW-1:0] ld_data = '0;
  logic          ld_ready, mem_we, mem_re, cpu_run, halted, done, pass, fail, timeout;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [31:0]   cycles;

  mips_boot_ctrl #(.ADDR_W(AW), .DATA_W(DW), .PROG_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clk1(clk1), .rst_n(rst_n), .start(start),
    .oper_addr(oper_addr), .oper_val(oper_val), .chk_addr(chk_addr), .exp_val(exp_val),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
    .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .cpu_run(cpu_run), .halted(halted), .done(done),
    .pass(pass), .fail(fail), .timeout(timeout), .cycles(cycles)
  );

  always #5 clk1 = ~clk1;

  int nvec = 0, nfail = 0, tot = 0;
  logic [31:0]   mem [0:1023];
  logic [31:0]   prog [0:31];
  logic [AW-1:0] waddr_q [$];
  logic [DW-1:0] wdata_q [$];
  int re_cnt = 0, both_cnt = 0, run_cnt = 0;
  int halt_at = 1000;
  logic force_halt = 1'b0;
  logic [AW-1:0] cur_oper = '0, cur_chk = '0;

  // What the stand-in core leaves at the result address
  function automatic logic [31:0] core_fn(input logic [31:0] x);
    logic [31:0] r;
    if (x < 32'd13) begin
      r = 32'd1;
      for (int i = 2; i <= int'(x); i++) r = r * 32'(i);
    end else begin
      r = x ^ 32'hA5A5_A5A5;
    end
    return r;
  endfunction

  // Stand-in core: HALTED rises on run cycle halt_at (1-based); force_halt models a stale flag
  assign halted = force_halt | (cpu_run && (run_cnt + 1 >= halt_at));

  // Memory model, core result store and port monitor
  always @(posedge clk1) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (cpu_run && halted && run_cnt >= 1) mem[cur_chk] <= core_fn(mem[cur_oper]);
    if (mem_re) mem_rdata <= mem[mem_addr];
    run_cnt <= cpu_run ? run_cnt + 1 : 0;
    if (mem_we) begin
      waddr_q.push_back(mem_addr);
      wdata_q.push_back(mem_wdata);
    end
    if (mem_re) re_cnt <= re_cnt + 1;
    if (mem_we && mem_re) both_cnt <= both_cnt + 1;
  end

  task automatic tick;
    @(negedge clk1);
    tot++;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_seq(input string nm, input int nw, input bit use_last, input bit gap,
                         input int h, input bit stale, input logic [31:0] delta,
                         input bit keep_prog, input bit glitch, input int rst_after,
                         input logic [AW-1:0] oaddr, input logic [31:0] oval,
                         input logic [AW-1:0] caddr);
    int base_w, base_re, acc, exp_acc, t0, k, eff, exp_lat;
    bit tmo;
    logic [31:0] expv, ea, ed;
    if (!keep_prog) for (int i = 0; i < nw; i++) prog[i] = $urandom;
    expv = core_fn(oval) + delta;
    eff  = stale ? 2 : ((h < 2) ? 2 : h);
    tmo  = TMO_EN && (eff > TMO);
    exp_acc = use_last ? nw : ((nw < DEPTH) ? nw : DEPTH);
    cur_oper = oaddr; cur_chk = caddr; halt_at = h; force_halt = stale;
    base_w = waddr_q.size(); base_re = re_cnt;
    oper_addr = oaddr; oper_val = oval; chk_addr = caddr; exp_val = expv; start = 1'b1;
    t0 = tot;
    tick;
    start = 1'b0;
    check({nm, ":ld_ready_load"}, ld_ready, 1);
    acc = 0;
    for (int i = 0; i < nw; i++) begin
      if (!ld_ready) break;
      if (gap) begin ld_valid = 1'b0; tick; end
      ld_valid = 1'b1; ld_data = prog[i]; ld_last = use_last && (i == nw - 1);
      if (glitch && i == 1) begin
        start = 1'b1; oper_addr = oaddr ^ 10'h155; oper_val = $urandom; chk_addr = caddr ^ 10'h0AA;
      end
      tick;
      start = 1'b0;
      acc++;
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    check({nm, ":accepted"}, acc, exp_acc);
    check({nm, ":ld_ready_after"}, ld_ready, 0);
    if (rst_after > 0) begin
      k = 0;
      while (!cpu_run && k < 200) begin tick; k++; end
      check({nm, ":reached_run"}, cpu_run, 1);
      for (int i = 0; i < rst_after; i++) tick;
      rst_n = 1'b0;
      tick;
      check({nm, ":rst_cpu_run"}, cpu_run, 0);
      check({nm, ":rst_done"}, done, 0);
      check({nm, ":rst_cycles"}, cycles, 0);
      check({nm, ":rst_ld_ready"}, ld_ready, 0);
      check({nm, ":rst_mem_we"}, mem_we, 0);
      rst_n = 1'b1;
      force_halt = 1'b0;
      tick;
      return;
    end
    k = 0;
    while (!done && k < 5000) begin tick; k++; end
    check({nm, ":done"}, done, 1);
    exp_lat = tmo ? (acc + 2 + TMO) : (acc + eff + 4);
    if (!gap) check({nm, ":latency"}, tot - t0, exp_lat);
    check({nm, ":pass"}, pass, (!tmo && delta == 0) ? 1 : 0);
    check({nm, ":fail"}, fail, (tmo || delta != 0) ? 1 : 0);
    check({nm, ":timeout"}, timeout, tmo ? 1 : 0);
    check({nm, ":cycles"}, cycles, tmo ? TMO : eff);
    check({nm, ":cpu_run_off"}, cpu_run, 0);
    check({nm, ":read_pulses"}, re_cnt - base_re, tmo ? 0 : 1);
    check({nm, ":n_writes"}, waddr_q.size() - base_w, acc + 1);
    for (int i = 0; i <= acc && base_w + i < waddr_q.size(); i++) begin
      ea = (i < acc) ? 32'(i) : 32'(oaddr);
      ed = (i < acc) ? prog[i] : oval;
      check($sformatf("%s:waddr%0d", nm, i), waddr_q[base_w + i], ea);
      check($sformatf("%s:wdata%0d", nm, i), wdata_q[base_w + i], ed);
    end
    tick; tick; tick;
    check({nm, ":done_held"}, done, 1);
    check({nm, ":pass_held"}, pass, (!tmo && delta == 0) ? 1 : 0);
    force_halt = 1'b0;
  endtask

  initial begin
    int nw, h;
    logic [AW-1:0] oa, ca;
    logic [31:0] ov, dl;

    rst_n = 1'b0;
    tick; tick; tick;
    check("rst:ld_ready", ld_ready, 0);
    check("rst:mem_we", mem_we, 0);
    check("rst:mem_re", mem_re, 0);
    check("rst:cpu_run", cpu_run, 0);
    check("rst:done", done, 0);
    check("rst:pass", pass, 0);
    check("rst:fail", fail, 0);
    check("rst:timeout", timeout, 0);
    check("rst:mem_addr", mem_addr, 0);
    check("rst:mem_wdata", mem_wdata, 0);
    check("rst:cycles", cycles, 0);
    rst_n = 1'b1;
    tick;

    prog[0] = 32'h280A00C8; prog[1] = 32'h28020001; prog[2] = 32'h0E94A000;
    prog[3] = 32'h21430000; prog[4] = 32'h0E94A000; prog[5] = 32'h14431000;
    prog[6] = 32'h2C630001; prog[7] = 32'h0E94A000; prog[8] = 32'h3460FFFC;
    prog[9] = 32'h2542FFFE; prog[10] = 32'hFC000000;
    h = int'($urandom_range(20, 40));
    run_seq("fact", 11, 1, 0, h, 0, 32'd0, 1, 0, 0, 10'd200, 32'd7, 10'd198);
    run_seq("mismatch", 11, 1, 0, h, 0, 32'd1, 1, 0, 0, 10'd200, 32'd7, 10'd198);
    run_seq("depth_cap", 20, 0, 0, 12, 0, 32'd0, 0, 0, 0, 10'd300, 32'd5, 10'd301);
    run_seq("backpressure", 9, 1, 1, 7, 0, 32'd0, 0, 0, 0, 10'd400, 32'd9, 10'd402);
    run_seq("stale_halt", 3, 1, 0, 1000, 1, 32'd0, 0, 0, 0, 10'd500, 32'd4, 10'd501);
    run_seq("halt_first", 2, 1, 0, 1, 0, 32'd0, 0, 0, 0, 10'd600, 32'd3, 10'd601);
    run_seq("start_glitch", 5, 1, 0, 6, 0, 32'd0, 0, 1, 0, 10'd700, 32'd6, 10'd702);

    for (int r = 0; r < 6; r++) begin
      nw = int'($urandom_range(1, DEPTH));
      h  = int'($urandom_range(2, 60));
      oa = 10'($urandom_range(DEPTH, 1023));
      do ca = 10'($urandom_range(DEPTH, 1023)); while (ca == oa);
      ov = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 12)) : $urandom;
      dl = ($urandom_range(0, 1) == 1) ? 32'd0 : 32'($urandom_range(1, 1000));
      run_seq($sformatf("rand%0d", r), nw, 1, 0, h, 0, dl, 0, 0, 0, oa, ov, ca);
    end

`ifdef BOOTCTL_TIMEOUT_EN
    run_seq("tmo_expire", 4, 1, 0, 1000, 0, 32'd0, 0, 0, 0, 10'd800, 32'd5, 10'd801);
    run_seq("tmo_tie", 4, 1, 0, TMO, 0, 32'd0, 0, 0, 0, 10'd810, 32'd5, 10'd811);
    run_seq("tmo_late", 4, 1, 0, TMO + 1, 0, 32'd0, 0, 0, 0, 10'd820, 32'd5, 10'd821);
`endif

    run_seq("rst_mid_run", 6, 1, 0, 1000, 0, 32'd0, 0, 0, 5, 10'd900, 32'd8, 10'd901);
    run_seq("after_rst", 6, 1, 0, 9, 0, 32'd0, 0, 0, 0, 10'd910, 32'd8, 10'd911);

    check("never_we_and_re", both_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
`default_nettype wire
